// File: rtl/idli_pcu_m.sv
// Multi-context bit-serial program counter: hold/inc/abs/rel per word, SLICE_W bits per cycle, LSB slice first.
// Latency: o_pc/o_pc_next/o_pc_tgt combinational per slice; updated PC readable from next word's ctr==0.
// Backpressure: none; free-running, the driver owns the ctr sequence and must keep it in order.
module idli_pcu_m #(
    parameter int                 SLICE_W  = 4,
    parameter int                 DATA_W   = 16,
    parameter int                 NCTX     = 2,
    parameter logic [DATA_W-1:0]  RESET_PC = '0,
    localparam int                NSLICE   = DATA_W / SLICE_W,
    localparam int                CTR_W    = $clog2(NSLICE),
    localparam int                CTX_W    = (NCTX > 1) ? $clog2(NCTX) : 1
) (
    input  logic               i_pc_gck,
    input  logic               i_pc_rst_n,
    input  logic [CTR_W-1:0]   i_pc_ctr,
    input  logic [CTX_W-1:0]   i_pc_ctx,
    input  logic [1:0]         i_pc_op,
    input  logic [SLICE_W-1:0] i_pc_data,
    output logic [SLICE_W-1:0] o_pc,
    output logic [SLICE_W-1:0] o_pc_next,
    output logic [SLICE_W-1:0] o_pc_tgt,
    output logic               o_pc_wrap
);

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INC  = 2'd1,
        OP_ABS  = 2'd2,
        OP_REL  = 2'd3
    } op_e;

    logic [DATA_W-1:0]  pc_q [NCTX];
    logic [DATA_W-1:0]  pc_d [NCTX];
    op_e                op_q, op_d, op_eff;
    logic [CTX_W-1:0]   ctx_q, ctx_d, ctx_eff;
    logic [CTX_W:0]     ctx_ext;
    logic               ctx_ok;
    logic               inc_c_q, inc_c_d, inc_cin;
    logic               rel_c_q, rel_c_d, rel_cin;
    logic [SLICE_W-1:0] rel_sum;
    logic [SLICE_W-1:0] cur_slice;
    logic [SLICE_W-1:0] rst_slice;
    logic               first_slice;
    logic               last_slice;

    assign first_slice = (i_pc_ctr == '0);
    assign last_slice  = (i_pc_ctr == CTR_W'(NSLICE - 1));

    // Word controls: take the live inputs at the first slice, otherwise replay the latched ones.
    always_comb begin
        op_eff  = first_slice ? op_e'(i_pc_op) : op_q;
        ctx_eff = (NCTX == 1) ? '0 : (first_slice ? i_pc_ctx : ctx_q);
        op_d    = op_eff;
        ctx_d   = ctx_eff;
        ctx_ext = {1'b0, ctx_eff};
        ctx_ok  = (ctx_ext < (CTX_W + 1)'(NCTX));
    end

    // Current slice: LSB end of the selected context, or the reset value slice while in reset.
    always_comb begin
        cur_slice = '0;
        rst_slice = '0;
        for (int i = 0; i < NCTX; i++) begin
            if (ctx_ok && (ctx_eff == CTX_W'(i))) begin
                cur_slice = pc_q[i][SLICE_W-1:0];
            end
        end
        for (int s = 0; s < NSLICE; s++) begin
            if (i_pc_ctr == CTR_W'(s)) begin
                rst_slice = RESET_PC[s*SLICE_W +: SLICE_W];
            end
        end
        o_pc = i_pc_rst_n ? cur_slice : rst_slice;
    end

    // Increment and relative-add ripple chains, both always running; op only picks the result.
    always_comb begin
        inc_cin = first_slice ? 1'b1 : inc_c_q;
        rel_cin = first_slice ? 1'b0 : rel_c_q;
        {inc_c_d, o_pc_next} = {1'b0, o_pc} + (SLICE_W + 1)'(inc_cin);
        {rel_c_d, rel_sum}   = {1'b0, o_pc} + {1'b0, i_pc_data} + (SLICE_W + 1)'(rel_cin);
    end

    // Write-back slice and wrap flag; a wrap is reported but the wrapped value is still written.
    always_comb begin
        o_pc_tgt  = o_pc;
        o_pc_wrap = 1'b0;
        case (op_eff)
            OP_HOLD: o_pc_tgt = o_pc;
            OP_INC:  o_pc_tgt = o_pc_next;
            OP_ABS:  o_pc_tgt = i_pc_data;
            OP_REL:  o_pc_tgt = rel_sum;
            default: o_pc_tgt = o_pc;
        endcase
        if (last_slice && i_pc_rst_n) begin
            case (op_eff)
                OP_INC:  o_pc_wrap = inc_c_d;
                // Signed offset: carry out XOR offset sign flags leaving [0, 2^DATA_W).
                OP_REL:  o_pc_wrap = rel_c_d ^ i_pc_data[SLICE_W-1];
                default: o_pc_wrap = 1'b0;
            endcase
        end
    end

    // Only the selected context rotates; the target slice enters at the MSB end.
    always_comb begin
        for (int i = 0; i < NCTX; i++) begin
            pc_d[i] = pc_q[i];
            if (ctx_ok && (ctx_eff == CTX_W'(i))) begin
                pc_d[i] = {o_pc_tgt, pc_q[i][DATA_W-1:SLICE_W]};
            end
        end
    end

    // State registers; reset discards any partial word immediately.
    always_ff @(posedge i_pc_gck or negedge i_pc_rst_n) begin
        if (!i_pc_rst_n) begin
            for (int i = 0; i < NCTX; i++) begin
                pc_q[i] <= RESET_PC;
            end
            op_q    <= OP_HOLD;
            ctx_q   <= '0;
            inc_c_q <= 1'b1;
            rel_c_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCTX; i++) begin
                pc_q[i] <= pc_d[i];
            end
            op_q    <= op_d;
            ctx_q   <= ctx_d;
            inc_c_q <= inc_c_d;
            rel_c_q <= rel_c_d;
        end
    end

    // A context index outside the implemented range is a driver bug; such words update nothing.
    ctx_range_a: assert property (@(posedge i_pc_gck) disable iff (!i_pc_rst_n)
        first_slice |-> ctx_ok);

endmodule

// File: tb/tb_idli_pcu_m.sv
module tb_idli_pcu_m;

    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] INC  = 2'd1;
    localparam logic [1:0] ABS  = 2'd2;
    localparam logic [1:0] REL  = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [1:0] i_pc_ctr;
    logic [0:0] i_pc_ctx;
    logic [1:0] i_pc_op;
    logic [3:0] i_pc_data;
    logic [3:0] o_pc;
    logic [3:0] o_pc_next;
    logic [3:0] o_pc_tgt;
    logic       o_pc_wrap;

    int checks = 0;
    int errors = 0;

    logic [15:0] pc_w;
    logic [15:0] next_w;
    logic [15:0] tgt_w;
    logic [3:0]  wrap_w;

    idli_pcu_m #(
        .SLICE_W  (4),
        .DATA_W   (16),
        .NCTX     (2),
        .RESET_PC (16'h0000)
    ) dut (
        .i_pc_gck   (clk),
        .i_pc_rst_n (rst_n),
        .i_pc_ctr   (i_pc_ctr),
        .i_pc_ctx   (i_pc_ctx),
        .i_pc_op    (i_pc_op),
        .i_pc_data  (i_pc_data),
        .o_pc       (o_pc),
        .o_pc_next  (o_pc_next),
        .o_pc_tgt   (o_pc_tgt),
        .o_pc_wrap  (o_pc_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice counter must advance 0,1,2,3,0,... at every active edge outside reset.
    logic [1:0] exp_ctr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ctr <= 2'd0;
        end else begin
            assert (i_pc_ctr === exp_ctr) else begin
                errors++;
                $error("FAIL ctr_order observed=%0d expected=%0d", i_pc_ctr, exp_ctr);
            end
            exp_ctr <= i_pc_ctr + 2'd1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [1:0] op, input logic ctx,
                         input logic [3:0] d);
        @(negedge clk);
        i_pc_ctr  = s;
        i_pc_op   = op;
        i_pc_ctx  = ctx;
        i_pc_data = d;
        #1;
    endtask

    // One full word; op_late is presented from slice 2 on (ignored by the DUT).
    task automatic run_word(input logic [1:0] op, input logic [1:0] op_late, input logic ctx,
                            input logic [15:0] data);
        for (int s = 0; s < 4; s++) begin
            drive(2'(s), (s < 2) ? op : op_late, ctx, data[s*4 +: 4]);
            pc_w[s*4 +: 4]   = o_pc;
            next_w[s*4 +: 4] = o_pc_next;
            tgt_w[s*4 +: 4]  = o_pc_tgt;
            wrap_w[s]        = o_pc_wrap;
        end
    endtask

    task automatic read_pc(input logic ctx);
        run_word(HOLD, HOLD, ctx, 16'h0000);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_pc_ctr  = 2'd0;
        i_pc_ctx  = 1'b0;
        i_pc_op   = HOLD;
        i_pc_data = 4'h0;
        #1;
        chk("reset_o_pc", {12'h0, o_pc}, 16'h0000);
        chk("reset_wrap", {15'h0, o_pc_wrap}, 16'h0000);
        chk("reset_next", {12'h0, o_pc_next}, 16'h0001);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: first INC after reset
        run_word(INC, INC, 1'b0, 16'h0000);
        chk("t1_pc", pc_w, 16'h0000);
        chk("t1_next", next_w, 16'h0001);
        chk("t1_wrap", {12'h0, wrap_w}, 16'h0000);
        read_pc(1'b0);
        chk("t1_read", pc_w, 16'h0001);

        // 2: carry ripple across slices
        run_word(ABS, ABS, 1'b0, 16'h00FF);
        chk("t2_abs_tgt", tgt_w, 16'h00FF);
        run_word(INC, INC, 1'b0, 16'h0000);
        chk("t2_pc", pc_w, 16'h00FF);
        chk("t2_next", next_w, 16'h0100);
        chk("t2_wrap", {12'h0, wrap_w}, 16'h0000);
        read_pc(1'b0);
        chk("t2_read", pc_w, 16'h0100);

        // 3: increment wraps at the top of the address space
        run_word(ABS, ABS, 1'b0, 16'hFFFF);
        run_word(INC, INC, 1'b0, 16'h0000);
        chk("t3_next", next_w, 16'h0000);
        chk("t3_wrap", {12'h0, wrap_w}, 16'h0008);
        read_pc(1'b0);
        chk("t3_read", pc_w, 16'h0000);

        // 4a: 0x0100 - 16, no wrap
        run_word(ABS, ABS, 1'b0, 16'h0100);
        run_word(REL, REL, 1'b0, 16'hFFF0);
        chk("t4a_tgt", tgt_w, 16'h00F0);
        chk("t4a_wrap", {12'h0, wrap_w}, 16'h0000);
        read_pc(1'b0);
        chk("t4a_read", pc_w, 16'h00F0);

        // 4b: 0x0008 - 16 underflows
        run_word(ABS, ABS, 1'b0, 16'h0008);
        run_word(REL, REL, 1'b0, 16'hFFF0);
        chk("t4b_tgt", tgt_w, 16'hFFF8);
        chk("t4b_wrap", {12'h0, wrap_w}, 16'h0008);
        read_pc(1'b0);
        chk("t4b_read", pc_w, 16'hFFF8);

        // 4c: 0xFFF8 + 16 overflows
        run_word(REL, REL, 1'b0, 16'h0010);
        chk("t4c_tgt", tgt_w, 16'h0008);
        chk("t4c_wrap", {12'h0, wrap_w}, 16'h0008);
        read_pc(1'b0);
        chk("t4c_read", pc_w, 16'h0008);

        // 5: contexts are independent
        run_word(ABS, ABS, 1'b0, 16'h0001);
        run_word(ABS, ABS, 1'b1, 16'h1234);
        read_pc(1'b1);
        chk("t5_ctx1", pc_w, 16'h1234);
        read_pc(1'b0);
        chk("t5_ctx0", pc_w, 16'h0001);
        chk("t5_hold_tgt", tgt_w, 16'h0001);
        chk("t5_hold_wrap", {12'h0, wrap_w}, 16'h0000);

        // 6a: op change mid-word is ignored
        run_word(INC, ABS, 1'b0, 16'hABCD);
        chk("t6a_tgt", tgt_w, 16'h0002);
        chk("t6a_wrap", {12'h0, wrap_w}, 16'h0000);
        read_pc(1'b0);
        chk("t6a_read", pc_w, 16'h0002);

        // 6b: reset mid-word
        run_word(ABS, ABS, 1'b1, 16'h5555);
        drive(2'd0, INC, 1'b0, 4'h0);
        drive(2'd1, INC, 1'b0, 4'h0);
        drive(2'd2, INC, 1'b0, 4'h0);
        rst_n = 1'b0;
        #1;
        chk("t6b_rst_pc", {12'h0, o_pc}, 16'h0000);
        chk("t6b_rst_wrap", {15'h0, o_pc_wrap}, 16'h0000);
        i_pc_ctr = 2'd0;
        i_pc_ctx = 1'b1;
        #1;
        chk("t6b_rst_ctx1", {12'h0, o_pc}, 16'h0000);
        @(posedge clk);
        #2 rst_n = 1'b1;
        read_pc(1'b0);
        chk("t6b_ctx0", pc_w, 16'h0000);
        read_pc(1'b1);
        chk("t6b_ctx1", pc_w, 16'h0000);
        run_word(INC, INC, 1'b0, 16'h0000);
        chk("t6b_inc_next", next_w, 16'h0001);
        read_pc(1'b0);
        chk("t6b_inc_read", pc_w, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idli_pcu_m.md
Name: idli_pcu_m

Overview:
Parametrised successor to the single-context bit-serial PC. Holds NCTX independent PC contexts, each DATA_W bits wide, and processes SLICE_W bits per cycle, LSB slice first. The per-word operation is hold, increment, absolute load or PC-relative add, and it is latched at the start of each word. Sits in the fetch path: it feeds the current and sequential PC slices to fetch and link capture, and takes branch data from the execute datapath.

Parameters:
SLICE_W, 4, bits processed per cycle.
DATA_W, 16, PC width; must be a multiple of SLICE_W, with NSLICE = DATA_W/SLICE_W >= 2.
NCTX, 2, number of PC contexts (>= 1).
RESET_PC, 0, reset value of every context.

Ports:
i_pc_gck  in  1  clock.
i_pc_rst_n  in  1  reset, asynchronous, active-low.
i_pc_ctr  in  $clog2(NSLICE)  slice index of the current cycle; the driver cycles it 0..NSLICE-1 in order.
i_pc_ctx  in  $clog2(NCTX) (min 1)  context select; sampled at ctr==0.
i_pc_op  in  2  0=HOLD, 1=INC, 2=ABS, 3=REL; sampled at ctr==0.
i_pc_data  in  SLICE_W  ABS address slice, or REL two's-complement offset slice; same slice index as ctr.
o_pc  out  SLICE_W  current slice of the selected context's PC.
o_pc_next  out  SLICE_W  slice of selected PC + 1 (link value), valid for any op.
o_pc_tgt  out  SLICE_W  slice being written back this cycle.
o_pc_wrap  out  1  address wrap flag; valid only at ctr==NSLICE-1, otherwise 0.

Behaviour:
- Storage: NCTX DATA_W-bit shift registers. Slice 0 is at the LSB end.
- Each cycle, the selected context shifts right by SLICE_W and o_pc_tgt enters at the MSB end.
- Non-selected contexts hold unchanged. Because the context only changes at a word boundary, every context stays slice-aligned.
- Sampling at ctr==0: op_eff/ctx_eff = i_pc_op/i_pc_ctx, used directly that cycle and latched into op_q/ctx_q.
- Sampling at ctr!=0: op_eff/ctx_eff = op_q/ctx_q. Changes to i_pc_op/i_pc_ctx mid-word are ignored.
- o_pc = LSB slice of context ctx_eff; purely combinational from state plus ctr==0 inputs.
- Increment chain: carry register inc_c. Carry-in = 1 at ctr==0, otherwise inc_c_q. {inc_c_d, o_pc_next} = o_pc + carry-in. Always runs, regardless of op.
- Relative chain: carry register rel_c. Carry-in = 0 at ctr==0, otherwise rel_c_q. {rel_c_d, rel_sum} = o_pc + i_pc_data + carry-in. Always runs.
- o_pc_tgt by op:
  - HOLD: o_pc.
  - INC: o_pc_next.
  - ABS: i_pc_data.
  - REL: rel_sum.
- o_pc_wrap at ctr==NSLICE-1:
  - INC: inc_c_d (0xFF..F -> 0).
  - REL: rel_c_d XOR MSB of i_pc_data, i.e. unsigned PC + signed offset left [0, 2^DATA_W).
  - HOLD/ABS: 0.
- A wrap is flagged only, not suppressed: the wrapped value is still written.
- Latency: the new PC is visible on o_pc from the next word's ctr==0, so updates are back-to-back with no bubbles.
- Reset, asynchronous, takes effect immediately (including mid-word; the partial word is discarded):
  - all contexts = RESET_PC;
  - op_q = HOLD; ctx_q = 0;
  - inc_c_q = 1; rel_c_q = 0.
- Output values during reset: o_pc = RESET_PC slice for the presented ctr/ctx; o_pc_wrap = 0.
- After reset release, the first word must start at ctr==0. A ctr sequence that is not in order gives undefined results; the bench asserts the ordering.
- i_pc_ctx >= NCTX is illegal: assertion, and no context updates.
- NCTX==1: the ctx port is ignored.

Test Plan:
1. Defaults, reset then INC word (ctr 0..3) -> o_pc slices 0,0,0,0; o_pc_next 1,0,0,0; next word reads PC 0x0001.
2. Carry ripple: ctx0=0x00FF, INC -> o_pc_next slices 0,0,1,0; PC becomes 0x0100; o_pc_wrap=0.
3. INC at 0xFFFF -> PC 0x0000; o_pc_wrap=1 at ctr 3 only.
4. REL with offset 0xFFF0 (-16), two cases:
   - PC 0x0100 -> 0x00F0, wrap=0.
   - PC 0x0008 -> 0xFFF8, wrap=1.
   - Also offset 0x0010 at PC 0xFFF8 -> 0x0008, wrap=1.
5. Contexts: ctx0=0x0001. ABS 0x1234 on ctx1 -> ctx1=0x1234, ctx0 still 0x0001. Then an HOLD word on ctx0 -> o_pc slices 1,0,0,0.
6. Robustness:
   - Toggle i_pc_op INC->ABS at ctr 2 -> the whole word still completes as INC.
   - Assert reset at ctr 2 -> all contexts read RESET_PC; the next word from ctr 0 behaves normally.
